// File: rtl/ps2_pkg.sv
// Shared constants and decoder state type for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0]  PS2_BREAK      = 8'hF0;
    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam logic [7:0]  PS2_PAUSE      = 8'hE1;
    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PS2_PAUSE_SKIP = 7;
    localparam int unsigned PS2_SKIP_W     = 3;
    localparam int unsigned PS2_BITCNT_W   = 4;

    typedef enum logic [2:0] {
        DEC_IDLE,
        DEC_BRK,
        DEC_EXT,
        DEC_EXT_BRK,
        DEC_SKIP
    } ps2_dec_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, clock glitch filter, falling-edge detect,
// 11-bit frame capture with start/parity/stop checks and a mid-frame timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned CNT_W = PS2_BITCNT_W;
    localparam logic [CNT_W-1:0] PAR_IDX  = CNT_W'(PS2_FRAME_BITS - 2);
    localparam logic [CNT_W-1:0] STOP_IDX = CNT_W'(PS2_FRAME_BITS - 1);

    logic [1:0]       clk_sync_q, clk_sync_d;
    logic [1:0]       dat_sync_q, dat_sync_d;
    logic             filt_q, filt_d;
    logic [FLT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fall;
    logic             dat;

    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk};
        dat_sync_d = {dat_sync_q[0], ps2_dat};
        dat        = dat_sync_q[1];

        // Filtered level only flips after FILTER_LEN consecutive disagreeing samples
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                fcnt_d = fcnt_q + FLT_W'(1);
            end
        end
        fall = filt_q & ~filt_d;

        bitcnt_d   = bitcnt_q;
        data_d     = data_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;

        if (fall) begin
            tmo_d = '0;
            if (bitcnt_q == '0) begin
                if (dat) begin
                    frame_err = 1'b1;
                end else begin
                    bitcnt_d = CNT_W'(1);
                end
            end else if (bitcnt_q < PAR_IDX) begin
                data_d   = {dat, data_q[7:1]};
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end else if (bitcnt_q == PAR_IDX) begin
                par_d    = dat;
                bitcnt_d = bitcnt_q + CNT_W'(1);
            end else begin
                bitcnt_d = '0;
                if (dat && (^{data_q, par_q})) begin
                    byte_valid = 1'b1;
                end else begin
                    frame_err = 1'b1;
                end
            end
        end else if (bitcnt_q != '0) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                bitcnt_d  = '0;
                tmo_d     = '0;
                frame_err = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end

        byte_data = data_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            bitcnt_q   <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            bitcnt_q   <= bitcnt_d;
            data_q     <= data_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
        end
    end

    // STOP_IDX documents the last bit position; the else-branch above handles it
    logic unused_stop_idx;
    assign unused_stop_idx = ^STOP_IDX;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: strips F0/E0/E1 prefixes and emits make/break events.
// Define PS2_EXTENDED_EN to add the `extended` output for E0-prefixed events.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] keycode,
    output logic       press,
    output logic       valid,
    output logic       err
`ifdef PS2_EXTENDED_EN
    ,
    output logic       extended
`endif
);

    logic [7:0]            byte_data;
    logic                  byte_valid;
    logic                  frame_err;

    ps2_dec_state_t        state_q, state_d;
    logic [PS2_SKIP_W-1:0] skip_q, skip_d;
    logic [7:0]            keycode_q, keycode_d;
    logic                  press_q, press_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  emit;
`ifdef PS2_EXTENDED_EN
    logic                  ext_q, ext_d;
`endif

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .FILTER_LEN     (FILTER_LEN)
    ) u_frame_rx (
        .Clk        (Clk),
        .Reset      (Reset),
        .ps2_clk    (PS2_CLK),
        .ps2_dat    (PS2_DAT),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        keycode_d = keycode_q;
        press_d   = press_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        emit      = 1'b0;
`ifdef PS2_EXTENDED_EN
        ext_d     = ext_q;
`endif

        if (frame_err) begin
            state_d = DEC_IDLE;
            skip_d  = '0;
            err_d   = 1'b1;
        end else if (byte_valid) begin
            case (state_q)
                DEC_IDLE: begin
                    if (byte_data == PS2_BREAK) begin
                        state_d = DEC_BRK;
                    end else if (byte_data == PS2_EXT) begin
                        state_d = DEC_EXT;
                    end else if (byte_data == PS2_PAUSE) begin
                        state_d = DEC_SKIP;
                        skip_d  = PS2_SKIP_W'(PS2_PAUSE_SKIP);
                    end else begin
                        emit = 1'b1;
                    end
                end
                DEC_BRK:     emit = 1'b1;
                DEC_EXT: begin
                    if (byte_data == PS2_BREAK) begin
                        state_d = DEC_EXT_BRK;
                    end else begin
                        emit = 1'b1;
                    end
                end
                DEC_EXT_BRK: emit = 1'b1;
                DEC_SKIP: begin
                    // Pause sequence bytes are swallowed silently
                    skip_d = skip_q - PS2_SKIP_W'(1);
                    if (skip_q <= PS2_SKIP_W'(1)) begin
                        state_d = DEC_IDLE;
                        skip_d  = '0;
                    end
                end
                default:     state_d = DEC_IDLE;
            endcase

            // Break/extended flavour of an event follows from the state it lands in
            if (emit) begin
                state_d   = DEC_IDLE;
                valid_d   = 1'b1;
                keycode_d = byte_data;
                press_d   = (state_q == DEC_IDLE) || (state_q == DEC_EXT);
`ifdef PS2_EXTENDED_EN
                ext_d     = (state_q == DEC_EXT) || (state_q == DEC_EXT_BRK);
`endif
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= DEC_IDLE;
            skip_q    <= '0;
            keycode_q <= 8'h00;
            press_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_EXTENDED_EN
            ext_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            skip_q    <= skip_d;
            keycode_q <= keycode_d;
            press_q   <= press_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
`ifdef PS2_EXTENDED_EN
            ext_q     <= ext_d;
`endif
        end
    end

    assign keycode  = keycode_q;
    assign press    = press_q;
    assign valid    = valid_q;
    assign err      = err_q;
`ifdef PS2_EXTENDED_EN
    assign extended = ext_q;
`endif

endmodule
